spatial_encoder_sequencer: RTL and testbench
============================================

# spatial_encoder_sequencer

Sequences one feature sample through the folded spatial encoder. Accepts a vector of quantized channel levels and addresses the item memory (IM, per channel) and continuous item memory (CIM, per level) ROMs in fold-major, channel-minor order. Streams the resulting IM/CIM fold pairs to the encoder at one beat per cycle, which is the rate the encoder requires once started. Holds the finished hypervector behind a valid/ready handshake until the consumer takes it.

## Interface
- NUM_CHANNEL, 32, channels per sample
- NUM_FOLDS, 8, folds per hypervector
- FOLD_WIDTH, 256, bits per fold
- NUM_LEVELS, 21, quantization levels
- LEVEL_WIDTH, 5, bits per channel level
- Derived widths:
  - CH_W = clog2(NUM_CHANNEL)
  - FOLD_W = clog2(NUM_FOLDS)
  - IM_AW = clog2(NUM_CHANNEL*NUM_FOLDS)
  - CIM_AW = clog2(NUM_LEVELS*NUM_FOLDS)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  sample offered
- sample_ready  out  1  sequencer can accept a sample
- sample_levels  in  NUM_CHANNEL*LEVEL_WIDTH  channel c level at bits [c*LEVEL_WIDTH +: LEVEL_WIDTH]
- rom_en  out  1  read enable shared by both ROMs; ROMs have 1-cycle read latency and hold data when rom_en=0
- im_addr  out  IM_AW  c*NUM_FOLDS+f
- cim_addr  out  CIM_AW  level*NUM_FOLDS+f
- im_data  in  FOLD_WIDTH  IM read data
- cim_data  in  FOLD_WIDTH  CIM read data
- enc_din_valid  out  1  start beat to encoder
- enc_din_ready  in  1  encoder idle
- enc_im  out  FOLD_WIDTH  IM fold to encoder
- enc_cim  out  FOLD_WIDTH  CIM fold to encoder
- hv_valid  out  1  encoder hvout complete and stable
- hv_ready  in  1  consumer accepts hypervector
- busy  out  1  state != IDLE

## Operation
- Beat index b = f*NUM_CHANNEL + c, b in 0..B-1, with B = NUM_FOLDS*NUM_CHANNEL.
- Beat b addresses channel c and fold f.
- States:
  - IDLE: sample_ready=1. On sample_valid fire, latch sample_levels, go to PREFETCH.
  - PREFETCH: rom_en=1, addresses for beat 0. Go to FIRE.
  - FIRE: enc_din_valid=1, enc_im/enc_cim = ROM data, addresses for beat 1, rom_en = enc_din_ready.
    - Stay in FIRE while enc_din_ready=0; ROM data holds.
    - On enc_din_ready=1 go to STREAM with beat counter b=1.
  - STREAM: enc_im/enc_cim = ROM data for beat b. If b+1 < B, rom_en=1 and addresses for beat b+1. Increment b each cycle; after b=B-1 go to DRAIN. enc_din_valid=0, since the encoder consumes unconditionally.
  - DRAIN: one cycle, enc_im=enc_cim=0. The encoder emits its last fold on this edge. Go to HOLD.
  - HOLD: hv_valid=1. On hv_ready go to IDLE.
- Address generation:
  - Counters are channel c (0..NUM_CHANNEL-1, wraps to 0 and increments f) and fold f.
  - Products are computed at full width, then truncated to the address width.
- Level clamp: a latched level ≥ NUM_LEVELS is treated as NUM_LEVELS-1.
- Outside FIRE/STREAM: enc_im, enc_cim, rom_en and addresses are all 0.
- NUM_CHANNEL=1 and NUM_FOLDS=1 must work.
  - With B=1, FIRE issues no next address (rom_en=0) and STREAM is skipped: FIRE goes directly to DRAIN.

## Timing
- Reset values:
  - state=IDLE, sample_ready=1, busy=0
  - hv_valid=0, enc_din_valid=0, rom_en=0
  - all addresses and enc_im/enc_cim = 0
- rst mid-operation: abandon the sample immediately; no hv_valid is produced. The encoder shares the same rst.
- Latency (enc_din_ready=1 throughout):
  - Sample accepted on the edge ending cycle T0.
  - PREFETCH T1, FIRE T2, STREAM T3..T(B+1), DRAIN T(B+2).
  - hv_valid rises at T(B+3).
- Every FIRE/STREAM cycle after the first encoder fire carries a new beat; there are no bubbles.
- hv_valid held with hv_ready=0: stays high, sample_ready stays 0. A new sample is blocked so the encoder hvout is not overwritten.
- Back-to-back: hv_ready at cycle Tn makes sample_ready=1 at Tn+1. Minimum sample period is B+4 cycles.
- sample_valid during a busy state is ignored; sample_levels is sampled only at fire.

## Test plan
- NUM_CHANNEL=3, NUM_FOLDS=2, levels {2,0,5}, hv_ready=1:
  - im_addr sequence is 0,2,4,1,3,5; cim_addr sequence is 4,0,10,5,1,11.
  - hv_valid is high at T9 for one cycle.
  - Encoder hvout matches a golden majority model.
- Same sample with enc_din_ready held 0 for 4 cycles in FIRE:
  - rom_en=0 and enc_din_valid=1 during the hold.
  - Streaming starts the cycle after ready; hv_valid at T13.
- hv_ready held 0 for 10 cycles with a second sample_valid asserted:
  - hv_valid stays 1 and sample_ready stays 0.
  - The second sample is accepted the cycle after the hv_ready handshake.
- Level 31 on channel 1 (NUM_LEVELS=21): cim_addr for channel 1 uses level 20, giving 40 for fold 0 and 41 for fold 1.
- rst pulsed during STREAM (beat 3):
  - All outputs return to reset values the next cycle.
  - No hv_valid is produced; a fresh sample then completes normally.
- NUM_CHANNEL=1, NUM_FOLDS=1: hv_valid at T4, im_addr=0.

Source files
------------

// File: rtl/spatial_encoder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spatial_encoder_sequencer
// Function : Sequences one quantized sample through the folded spatial encoder.
//            IM/CIM ROMs are read fold-major, channel-minor, and each fold pair
//            is streamed at one beat per cycle.
// Revision : 1.0
// ============================================================================
module spatial_encoder_sequencer #(
  parameter int  NUM_CHANNEL = 32,
  parameter int  NUM_FOLDS   = 8,
  parameter int  FOLD_WIDTH  = 256,
  parameter int  NUM_LEVELS  = 21,
  parameter int  LEVEL_WIDTH = 5,
  localparam int CH_W   = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1,
  localparam int FOLD_W = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  localparam int IM_AW  = (NUM_CHANNEL * NUM_FOLDS > 1) ? $clog2(NUM_CHANNEL * NUM_FOLDS) : 1,
  localparam int CIM_AW = (NUM_LEVELS * NUM_FOLDS > 1) ? $clog2(NUM_LEVELS * NUM_FOLDS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [NUM_CHANNEL*LEVEL_WIDTH-1:0] sample_levels,
  output logic                               rom_en,
  output logic [IM_AW-1:0]                   im_addr,
  output logic [CIM_AW-1:0]                  cim_addr,
  input  logic [FOLD_WIDTH-1:0]              im_data,
  input  logic [FOLD_WIDTH-1:0]              cim_data,
  output logic                               enc_din_valid,
  input  logic                               enc_din_ready,
  output logic [FOLD_WIDTH-1:0]              enc_im,
  output logic [FOLD_WIDTH-1:0]              enc_cim,
  output logic                               hv_valid,
  input  logic                               hv_ready,
  output logic                               busy
);

  localparam int NUM_BEATS = NUM_CHANNEL * NUM_FOLDS;
  localparam int BEAT_W    = $clog2(NUM_BEATS + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREFETCH = 3'd1;
  localparam logic [2:0] S_FIRE     = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;

  logic [2:0]                         state_q, state_d;
  logic [NUM_CHANNEL*LEVEL_WIDTH-1:0] levels_q, levels_d;
  logic [CH_W-1:0]                    ch_q, ch_d;
  logic [FOLD_W-1:0]                  fold_q, fold_d;
  logic [BEAT_W-1:0]                  beat_q, beat_d;
  logic                               advance;
  logic                               has_next;
  logic [LEVEL_WIDTH-1:0]             level_raw, level_clamped;
  logic [LEVEL_WIDTH-1:0]             level_arr [NUM_CHANNEL];

  for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_level_unpack
    assign level_arr[g] = levels_q[g*LEVEL_WIDTH +: LEVEL_WIDTH];
  end

  // ch_q/fold_q always point one beat ahead of the fold pair on the encoder bus
  always_comb begin
    has_next = 1'b0;
    if (state_q == S_FIRE) begin
      has_next = (NUM_BEATS > 1);
    end else if (state_q == S_STREAM) begin
      has_next = (32'(beat_q) + 32'd1) < 32'(NUM_BEATS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      levels_q <= '0;
      ch_q     <= '0;
      fold_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      levels_q <= levels_d;
      ch_q     <= ch_d;
      fold_q   <= fold_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    levels_d = levels_q;
    ch_d     = ch_q;
    fold_d   = fold_q;
    beat_d   = beat_q;
    advance  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          levels_d = sample_levels;
          ch_d     = '0;
          fold_d   = '0;
          state_d  = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        advance = 1'b1;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        if (enc_din_ready) begin
          advance = 1'b1;
          beat_d  = BEAT_W'(1);
          state_d = (NUM_BEATS > 1) ? S_STREAM : S_DRAIN;
        end
      end
      S_STREAM: begin
        advance = 1'b1;
        beat_d  = beat_q + 1'b1;
        if (!has_next) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_HOLD;
      S_HOLD: begin
        if (hv_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (ch_q == CH_W'(NUM_CHANNEL - 1)) begin
        ch_d   = '0;
        fold_d = fold_q + 1'b1;
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  always_comb begin
    level_raw     = level_arr[ch_q];
    level_clamped = (32'(level_raw) >= 32'(NUM_LEVELS)) ? LEVEL_WIDTH'(NUM_LEVELS - 1) : level_raw;
    sample_ready  = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    hv_valid      = (state_q == S_HOLD);
    enc_din_valid = (state_q == S_FIRE);
    rom_en        = 1'b0;
    im_addr       = '0;
    cim_addr      = '0;
    enc_im        = '0;
    enc_cim       = '0;
    case (state_q)
      S_PREFETCH: begin
        rom_en   = 1'b1;
        im_addr  = IM_AW'(32'(ch_q) * 32'(NUM_FOLDS) + 32'(fold_q));
        cim_addr = CIM_AW'(32'(level_clamped) * 32'(NUM_FOLDS) + 32'(fold_q));
      end
      S_FIRE, S_STREAM: begin
        enc_im  = im_data;
        enc_cim = cim_data;
        if (has_next) begin
          // While FIRE waits on the encoder the ROM must not advance, so its data holds
          rom_en   = (state_q == S_STREAM) ? 1'b1 : enc_din_ready;
          im_addr  = IM_AW'(32'(ch_q) * 32'(NUM_FOLDS) + 32'(fold_q));
          cim_addr = CIM_AW'(32'(level_clamped) * 32'(NUM_FOLDS) + 32'(fold_q));
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spatial_encoder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spatial_encoder_sequencer
// Function : Scoreboard bench for spatial_encoder_sequencer (3x2 and 1x1 builds).
// Revision : 1.0
// ============================================================================
module tb_spatial_encoder_sequencer;

  localparam int NC = 3, NF = 2, FW = 8, NL = 21, LW = 5, NB = NC * NF;
  localparam int IM_AW = 3, CIM_AW = 6, CIM1_AW = 5;

  typedef int tab_t [NB];

  localparam logic [NC*LW-1:0] LV_A  = {5'd5, 5'd0, 5'd2};
  localparam logic [NC*LW-1:0] LV_31 = {5'd5, 5'd31, 5'd2};
  localparam logic [NC*LW-1:0] LV_B  = {5'd21, 5'd7, 5'd1};

  tab_t t_im      = '{0, 2, 4, 1, 3, 5};
  tab_t t_cim_a   = '{4, 0, 10, 5, 1, 11};
  tab_t t_cim_31  = '{4, 40, 10, 5, 41, 11};
  tab_t t_cim_b   = '{2, 14, 40, 3, 15, 41};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              sample_valid, sample_ready, rom_en, enc_din_valid, enc_din_ready;
  logic              hv_valid, hv_ready, busy;
  logic [NC*LW-1:0]  sample_levels;
  logic [IM_AW-1:0]  im_addr;
  logic [CIM_AW-1:0] cim_addr;
  logic [FW-1:0]     im_data, cim_data, enc_im, enc_cim;

  logic               sv1, sr1, rom_en1, edv1, edr1, hvv1, hvr1, busy1;
  logic [LW-1:0]      lv1;
  logic [0:0]         im_addr1;
  logic [CIM1_AW-1:0] cim_addr1;
  logic [FW-1:0]      im_data1, cim_data1, enc_im1, enc_cim1;

  spatial_encoder_sequencer #(
    .NUM_CHANNEL(NC), .NUM_FOLDS(NF), .FOLD_WIDTH(FW), .NUM_LEVELS(NL), .LEVEL_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_levels(sample_levels),
    .rom_en(rom_en), .im_addr(im_addr), .cim_addr(cim_addr),
    .im_data(im_data), .cim_data(cim_data),
    .enc_din_valid(enc_din_valid), .enc_din_ready(enc_din_ready),
    .enc_im(enc_im), .enc_cim(enc_cim),
    .hv_valid(hv_valid), .hv_ready(hv_ready), .busy(busy)
  );

  spatial_encoder_sequencer #(
    .NUM_CHANNEL(1), .NUM_FOLDS(1), .FOLD_WIDTH(FW), .NUM_LEVELS(NL), .LEVEL_WIDTH(LW)
  ) dut1 (
    .clk(clk), .rst(rst),
    .sample_valid(sv1), .sample_ready(sr1), .sample_levels(lv1),
    .rom_en(rom_en1), .im_addr(im_addr1), .cim_addr(cim_addr1),
    .im_data(im_data1), .cim_data(cim_data1),
    .enc_din_valid(edv1), .enc_din_ready(edr1),
    .enc_im(enc_im1), .enc_cim(enc_cim1),
    .hv_valid(hvv1), .hv_ready(hvr1), .busy(busy1)
  );

  function automatic logic [FW-1:0] im_rom(input int a);
    return FW'(8'h10 + a);
  endfunction
  function automatic logic [FW-1:0] cim_rom(input int a);
    return FW'(8'h80 + a);
  endfunction

  // ROM models: one-cycle read latency, data holds while rom_en is low
  always @(posedge clk) begin
    if (rom_en) begin
      im_data  <= im_rom(int'(im_addr));
      cim_data <= cim_rom(int'(cim_addr));
    end
    if (rom_en1) begin
      im_data1  <= im_rom(int'(im_addr1));
      cim_data1 <= cim_rom(int'(cim_addr1));
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name);
    total++;
    $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  int             qa_im[$], qa_cim[$], qh[$];
  logic [FW-1:0]  qb_im[$], qb_cim[$];

  task automatic push_sample(input tab_t im, input tab_t cim);
    for (int i = 0; i < NB; i++) begin
      qa_im.push_back(im[i]);
      qa_cim.push_back(cim[i]);
      qb_im.push_back(im_rom(im[i]));
      qb_cim.push_back(cim_rom(cim[i]));
    end
  endtask

  // Monitor acts as the encoder: one fire beat, then NB-1 unconditional beats
  int   stream_left = 0;
  logic hv_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stream_left = 0;
      hv_prev     = 1'b0;
    end else begin
      if (rom_en) begin
        if (qa_im.size() == 0) note_fail("rom_addr_extra");
        else begin
          chk("im_addr", im_addr, qa_im.pop_front());
          chk("cim_addr", cim_addr, qa_cim.pop_front());
        end
      end
      if (stream_left > 0 || (enc_din_valid && enc_din_ready)) begin
        if (stream_left > 0) stream_left--;
        else stream_left = NB - 1;
        if (qb_im.size() == 0) note_fail("beat_extra");
        else begin
          chk("enc_im", enc_im, qb_im.pop_front());
          chk("enc_cim", enc_cim, qb_cim.pop_front());
        end
      end
      if (hv_valid && !hv_prev) begin
        if (qh.size() == 0) note_fail("hv_valid_extra");
        else chk("hv_rise_cycle", cyc, qh.pop_front());
      end
      hv_prev = hv_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NC*LW-1:0] lv, output int t0);
    int g = 0;
    sample_levels = lv;
    sample_valid  = 1'b1;
    while (!sample_ready && g < 100) begin
      step();
      g++;
    end
    if (!sample_ready) note_fail("send_timeout");
    t0 = cyc;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_hv();
    int g = 0;
    @(negedge clk);
    while (!hv_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!hv_valid) note_fail("hv_timeout");
  endtask

  task automatic finish_sample(input string tag);
    wait_hv();
    step();
    @(negedge clk);
    chk({tag, "_hv_one_cycle"}, hv_valid, 0);
    chk({tag, "_ready_after"}, sample_ready, 1);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sample_ready"}, sample_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hv_valid"}, hv_valid, 0);
    chk({tag, "_enc_din_valid"}, enc_din_valid, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_cim_addr"}, cim_addr, 0);
    chk({tag, "_enc_im"}, enc_im, 0);
    chk({tag, "_enc_cim"}, enc_cim, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int t0;
    int seen;
    sample_valid = 1'b0; sample_levels = '0; enc_din_ready = 1'b1; hv_ready = 1'b1;
    sv1 = 1'b0; lv1 = '0; edr1 = 1'b1; hvr1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset1_ready", sr1, 1);
    chk("reset1_hv", hvv1, 0);
    step();

    // Nominal sample
    push_sample(t_im, t_cim_a);
    send(LV_A, t0);
    qh.push_back(t0 + NB + 3);
    finish_sample("nominal");

    // Encoder busy for 4 cycles in FIRE
    enc_din_ready = 1'b0;
    push_sample(t_im, t_cim_a);
    send(LV_A, t0);
    qh.push_back(t0 + NB + 3 + 4);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_rom_en", rom_en, 0);
      chk("stall_din_valid", enc_din_valid, 1);
      step();
    end
    enc_din_ready = 1'b1;
    finish_sample("stall");

    // Level clamp on channel 1
    push_sample(t_im, t_cim_31);
    send(LV_31, t0);
    qh.push_back(t0 + NB + 3);
    finish_sample("clamp");

    // Consumer back-pressure with a second sample pending
    hv_ready = 1'b0;
    push_sample(t_im, t_cim_a);
    send(LV_A, t0);
    qh.push_back(t0 + NB + 3);
    wait_hv();
    push_sample(t_im, t_cim_b);
    step();
    sample_levels = LV_B;
    sample_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_hv_valid", hv_valid, 1);
      chk("hold_sample_ready", sample_ready, 0);
      step();
    end
    hv_ready = 1'b1;
    @(negedge clk);
    chk("handshake_hv_valid", hv_valid, 1);
    step();
    chk("accept_after_handshake", sample_ready, 1);
    t0 = cyc;
    step();
    sample_valid = 1'b0;
    qh.push_back(t0 + NB + 3);
    finish_sample("second");

    // Reset during STREAM beat 3
    push_sample(t_im, t_cim_a);
    send(LV_A, t0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    qa_im.delete(); qa_cim.delete(); qb_im.delete(); qb_cim.delete(); qh.delete();
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    seen = 0;
    repeat (12) begin
      step();
      @(negedge clk);
      if (hv_valid) seen = 1;
    end
    chk("no_hv_after_rst", seen, 0);
    step();
    push_sample(t_im, t_cim_a);
    send(LV_A, t0);
    qh.push_back(t0 + NB + 3);
    finish_sample("post_rst");

    // Single channel, single fold build
    sv1 = 1'b1;
    lv1 = 5'd9;
    t0  = cyc;
    step();
    sv1 = 1'b0;
    @(negedge clk);
    chk("one_prefetch_rom_en", rom_en1, 1);
    chk("one_im_addr", im_addr1, 0);
    chk("one_cim_addr", cim_addr1, 9);
    chk("one_busy", busy1, 1);
    step();
    @(negedge clk);
    chk("one_fire_valid", edv1, 1);
    chk("one_fire_rom_en", rom_en1, 0);
    chk("one_fire_im", enc_im1, im_rom(0));
    chk("one_fire_cim", enc_cim1, cim_rom(9));
    step();
    @(negedge clk);
    chk("one_drain_im", enc_im1, 0);
    chk("one_drain_hv", hvv1, 0);
    step();
    @(negedge clk);
    chk("one_hv_valid", hvv1, 1);
    chk("one_latency", cyc - t0, 4);
    step();
    @(negedge clk);
    chk("one_hv_done", hvv1, 0);
    chk("one_ready", sr1, 1);

    chk("addr_queue_left", qa_im.size(), 0);
    chk("beat_queue_left", qb_im.size(), 0);
    chk("hv_queue_left", qh.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
